// File: rtl/tty.sv
// TTY: 8N1 UART with independent receiver and transmitter.
// Each bit lasts DIV = CLK_FREQ/BAUD clock cycles. SRX is brought into the
// clock domain through a two-flop synchronizer. The receiver samples each bit
// at its midpoint. When ECHO is nonzero, each good received byte is held in a
// one-entry echo register. The transmitter sends that byte before any host
// byte.
module tty #(
    parameter int BAUD     = 115200,
    parameter int ECHO     = 0,
    parameter int CLK_FREQ = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SRX,
    output logic       STX,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

    // Transmit path state
    tx_state_t      r_tx_state;
    logic [CW-1:0]  r_tx_cnt;
    logic [2:0]     r_tx_bit;
    logic [7:0]     r_tx_shift;
    logic           r_stx;
    logic           r_tx_ready;

    tx_state_t      w_tx_state_nxt;
    logic [CW-1:0]  w_tx_cnt_nxt;
    logic [2:0]     w_tx_bit_nxt;
    logic [7:0]     w_tx_shift_nxt;
    logic           w_stx_nxt;
    logic           w_tx_ready_nxt;

    logic           w_tx_free;
    logic           w_launch_echo;
    logic           w_launch_host;
    logic           w_launch;
    logic [7:0]     w_launch_byte;

    // Echo register
    logic           r_echo_full;
    logic [7:0]     r_echo_data;
    logic           w_echo_full_nxt;
    logic [7:0]     w_echo_data_nxt;

    // Receive path state
    logic           r_rx_sync1;
    logic           r_rx_sync2;
    rx_state_t      r_rx_state;
    logic [CW-1:0]  r_rx_cnt;
    logic [2:0]     r_rx_bit;
    logic [7:0]     r_rx_shift;
    logic [7:0]     r_rx_data;
    logic           r_rx_valid;
    logic           r_rx_ferr;

    rx_state_t      w_rx_state_nxt;
    logic [CW-1:0]  w_rx_cnt_nxt;
    logic [2:0]     w_rx_bit_nxt;
    logic [7:0]     w_rx_shift_nxt;
    logic           w_rx;
    logic           w_rx_stop_tick;
    logic           w_rx_good;
    logic           w_rx_ferr;

    assign STX          = r_stx;
    assign tx_ready     = r_tx_ready;
    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_frame_err = r_rx_ferr;

    // ---------------------------------------------------------------- TX ----
    // The line is free in IDLE and in the last cycle of the stop bit. A new
    // frame can start in that cycle, so back-to-back frames leave no idle gap.
    // A pending echo byte wins over a host byte.
    assign w_tx_free     = (r_tx_state == TX_IDLE) ||
                           ((r_tx_state == TX_STOP) && (r_tx_cnt == CNT_LAST));
    assign w_launch_echo = r_echo_full && w_tx_free;
    assign w_launch_host = tx_valid && r_tx_ready && !w_launch_echo;
    assign w_launch      = w_launch_echo || w_launch_host;
    assign w_launch_byte = w_launch_echo ? r_echo_data : tx_data;

    // TX state register and registered line/ready outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= CNT_ZERO;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_stx      <= 1'b1;
            r_tx_ready <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_stx      <= w_stx_nxt;
            r_tx_ready <= w_tx_ready_nxt;
        end
    end

    // TX next-state: bit timing, data shifting and frame launch
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + CNT_ONE;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_nxt = CNT_ZERO;
                if (w_launch) begin
                    w_tx_state_nxt = TX_START;
                    w_tx_shift_nxt = w_launch_byte;
                end else begin
                    w_tx_state_nxt = TX_IDLE;
                end
            end
            TX_START: begin
                if (r_tx_cnt == CNT_LAST) begin
                    w_tx_state_nxt = TX_DATA;
                    w_tx_cnt_nxt   = CNT_ZERO;
                    w_tx_bit_nxt   = 3'd0;
                end else begin
                    w_tx_state_nxt = TX_START;
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == CNT_LAST) begin
                    w_tx_cnt_nxt = CNT_ZERO;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nxt = TX_STOP;
                    end else begin
                        w_tx_bit_nxt   = r_tx_bit + 3'd1;
                        w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                    end
                end else begin
                    w_tx_state_nxt = TX_DATA;
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == CNT_LAST) begin
                    w_tx_cnt_nxt = CNT_ZERO;
                    if (w_launch) begin
                        w_tx_state_nxt = TX_START;
                        w_tx_shift_nxt = w_launch_byte;
                    end else begin
                        w_tx_state_nxt = TX_IDLE;
                    end
                end else begin
                    w_tx_state_nxt = TX_STOP;
                end
            end
            default: begin
                w_tx_state_nxt = TX_IDLE;
                w_tx_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // TX outputs: decode the next state, so STX and tx_ready come from flops
    // and are valid in the same cycle as the state they describe.
    always_comb begin
        case (w_tx_state_nxt)
            TX_IDLE:  w_stx_nxt = 1'b1;
            TX_START: w_stx_nxt = 1'b0;
            TX_DATA:  w_stx_nxt = w_tx_shift_nxt[0];
            TX_STOP:  w_stx_nxt = 1'b1;
            default:  w_stx_nxt = 1'b1;
        endcase
        if ((w_tx_state_nxt == TX_IDLE) ||
            ((w_tx_state_nxt == TX_STOP) && (w_tx_cnt_nxt == CNT_LAST))) begin
            w_tx_ready_nxt = !w_echo_full_nxt;
        end else begin
            w_tx_ready_nxt = 1'b0;
        end
    end

    // -------------------------------------------------------------- ECHO ----
    // Echo register next value. The register loads only when it is empty. A
    // good byte that arrives while it is full is dropped, even in the cycle
    // where the pending byte is launched.
    always_comb begin
        w_echo_full_nxt = r_echo_full;
        w_echo_data_nxt = r_echo_data;
        if (ECHO == 0) begin
            w_echo_full_nxt = 1'b0;
        end else begin
            if (w_launch_echo) begin
                w_echo_full_nxt = 1'b0;
            end else begin
                w_echo_full_nxt = r_echo_full;
            end
            if (w_rx_good && !r_echo_full) begin
                w_echo_full_nxt = 1'b1;
                w_echo_data_nxt = r_rx_shift;
            end else begin
                w_echo_data_nxt = r_echo_data;
            end
        end
    end

    // Echo register storage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_echo_full <= 1'b0;
            r_echo_data <= 8'h00;
        end else begin
            r_echo_full <= w_echo_full_nxt;
            r_echo_data <= w_echo_data_nxt;
        end
    end

    // ---------------------------------------------------------------- RX ----
    // Two-flop synchronizer for the asynchronous SRX line
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
        end else begin
            r_rx_sync1 <= SRX;
            r_rx_sync2 <= r_rx_sync1;
        end
    end

    assign w_rx = r_rx_sync2;

    // RX state register and registered byte/pulse outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= CNT_ZERO;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_data  <= w_rx_good ? r_rx_shift : r_rx_data;
            r_rx_valid <= w_rx_good;
            r_rx_ferr  <= w_rx_ferr;
        end
    end

    // RX next-state: the start bit is checked at its midpoint. Each later
    // sample comes one full bit period after the previous one.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + CNT_ONE;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nxt = CNT_ZERO;
                if (!w_rx) begin
                    w_rx_state_nxt = RX_START;
                end else begin
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            RX_START: begin
                if (r_rx_cnt == CNT_HALF) begin
                    w_rx_cnt_nxt = CNT_ZERO;
                    w_rx_bit_nxt = 3'd0;
                    if (w_rx) begin
                        w_rx_state_nxt = RX_IDLE;
                    end else begin
                        w_rx_state_nxt = RX_DATA;
                    end
                end else begin
                    w_rx_state_nxt = RX_START;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == CNT_LAST) begin
                    w_rx_cnt_nxt   = CNT_ZERO;
                    w_rx_shift_nxt = {w_rx, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_nxt = RX_STOP;
                    end else begin
                        w_rx_bit_nxt = r_rx_bit + 3'd1;
                    end
                end else begin
                    w_rx_state_nxt = RX_DATA;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == CNT_LAST) begin
                    w_rx_cnt_nxt = CNT_ZERO;
                    if (w_rx) begin
                        w_rx_state_nxt = RX_IDLE;
                    end else begin
                        w_rx_state_nxt = RX_WAIT_IDLE;
                    end
                end else begin
                    w_rx_state_nxt = RX_STOP;
                end
            end
            RX_WAIT_IDLE: begin
                w_rx_cnt_nxt = CNT_ZERO;
                if (w_rx) begin
                    w_rx_state_nxt = RX_IDLE;
                end else begin
                    w_rx_state_nxt = RX_WAIT_IDLE;
                end
            end
            default: begin
                w_rx_state_nxt = RX_IDLE;
                w_rx_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // RX outputs: at the stop-bit sample, report a good byte or a framing error
    always_comb begin
        w_rx_stop_tick = (r_rx_state == RX_STOP) && (r_rx_cnt == CNT_LAST);
        w_rx_good      = w_rx_stop_tick && w_rx;
        w_rx_ferr      = w_rx_stop_tick && !w_rx;
    end

endmodule

// File: tb/tb_tty.sv
// Directed testbench for tty. Instance u0 runs with ECHO=0 and instance u1
// runs with ECHO=1, both at 25 MHz / 115200 baud (DIV = 217).
module tb_tty;

    localparam int DIV  = 217;
    localparam int HALF = 108;

    logic       clk = 1'b0;
    logic       rst0, rst1, srx0, srx1, stx0, stx1;
    logic [7:0] txd0, txd1, rxd0, rxd1;
    logic       txv0, txv1, rdy0, rdy1, rxv0, rxv1, fe0, fe1;

    always #5 clk = ~clk;

    tty #(115200, 0, 25000000) u0 (
        .clk(clk), .rst(rst0), .SRX(srx0), .STX(stx0),
        .tx_data(txd0), .tx_valid(txv0), .tx_ready(rdy0),
        .rx_data(rxd0), .rx_valid(rxv0), .rx_frame_err(fe0)
    );

    tty #(115200, 1, 25000000) u1 (
        .clk(clk), .rst(rst1), .SRX(srx1), .STX(stx1),
        .tx_data(txd1), .tx_valid(txv1), .tx_ready(rdy1),
        .rx_data(rxd1), .rx_valid(rxv1), .rx_frame_err(fe1)
    );

    int vectors = 0;
    int miscompares = 0;
    int nv = 0;
    int nf = 0;
    int lows = 0;

    // Echo-instance event recorder and STX decoder, sampled on falling edges
    int         ncyc = 0;
    int         v1_cyc = -1;
    int         rise_cyc = -1;
    int         f_cyc = 0;
    int         mon_done = 0;
    int         mon_off;
    logic       rdy_at_v = 1'b1;
    logic       prev_stx = 1'b1;
    logic       prev_rdy = 1'b0;
    logic       mon_busy = 1'b0;
    logic       mon_stop = 1'b0;
    logic [7:0] mon_bits = 8'h00;
    logic [7:0] mon_byte = 8'h00;

    always_comb mon_off = ncyc - f_cyc - HALF;

    always @(negedge clk) begin
        ncyc     <= ncyc + 1;
        prev_stx <= stx1;
        prev_rdy <= rdy1;
        if (rxv1 === 1'b1) begin
            v1_cyc   <= ncyc;
            rdy_at_v <= rdy1;
        end
        if (prev_rdy === 1'b0 && rdy1 === 1'b1) rise_cyc <= ncyc;
        if (rst1) begin
            mon_busy <= 1'b0;
        end else if (!mon_busy) begin
            if (prev_stx === 1'b1 && stx1 === 1'b0) begin
                mon_busy <= 1'b1;
                f_cyc    <= ncyc;
            end
        end else if (mon_off >= 0 && (mon_off % DIV) == 0) begin
            if (mon_off / DIV >= 1 && mon_off / DIV <= 8) begin
                mon_bits[mon_off / DIV - 1] <= stx1;
            end else if (mon_off / DIV == 9) begin
                mon_stop <= stx1;
                mon_byte <= mon_bits;
                mon_done <= mon_done + 1;
                mon_busy <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one RX line for a number of cycles and count output pulses
    task automatic drive_line(input int sel, input logic lvl, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (sel == 1) srx1 = lvl; else srx0 = lvl;
            tick;
            if (sel == 1) begin
                if (rxv1) nv++;
                if (fe1) nf++;
            end else begin
                if (rxv0) nv++;
                if (fe0) nf++;
            end
        end
    endtask

    task automatic rx_frame(input int sel, input logic [7:0] d, input logic stopb);
        logic [9:0] f;
        f = {stopb, d, 1'b0};
        for (int b = 0; b < 10; b++) drive_line(sel, f[b], DIV);
    endtask

    // The caller has set txv0/txd0 in the acceptance cycle. This task checks
    // STX of u0 for every cycle of the frame and checks tx_ready as well.
    task automatic tx_frame_check(input logic [7:0] d, input string tag);
        logic [9:0] f;
        int bad;
        int rdy_hi;
        f = {1'b1, d, 1'b0};
        rdy_hi = 0;
        tick;
        txv0 = 1'b0;
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int k = 0; k < DIV; k++) begin
                if (stx0 !== f[b]) bad++;
                if (b == 9 && k == DIV - 1) begin
                    chk({tag, " tx_ready at 10*DIV"}, rdy0, 1);
                end else begin
                    if (rdy0 !== 1'b0) rdy_hi++;
                    tick;
                end
            end
            chk($sformatf("%s STX bit%0d wrong cycles", tag, b), bad, 0);
        end
        chk({tag, " tx_ready high mid-frame cycles"}, rdy_hi, 0);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; srx0 = 1'b1; srx1 = 1'b1;
        txv0 = 1'b0; txv1 = 1'b0; txd0 = 8'h00; txd1 = 8'h00;

        // Reset for 400 cycles, then release
        repeat (400) tick;
        rst0 = 1'b0; rst1 = 1'b0;
        tick;
        chk("rst STX", stx0, 1);
        chk("rst tx_ready", rdy0, 1);
        chk("rst rx_valid", rxv0, 0);
        chk("rst rx_frame_err", fe0, 0);
        chk("rst rx_data", rxd0, 8'h00);
        chk("rst echo STX", stx1, 1);
        chk("rst echo tx_ready", rdy1, 1);

        // Transmit 0x55, then 0x0F back-to-back
        txd0 = 8'h55; txv0 = 1'b1;
        tx_frame_check(8'h55, "tx55");
        txd0 = 8'h0F; txv0 = 1'b1;
        tx_frame_check(8'h0F, "tx0f");
        tick;
        chk("tx idle STX", stx0, 1);
        chk("tx idle ready", rdy0, 1);

        // Receive a good 0xA5 frame
        nv = 0; nf = 0;
        rx_frame(0, 8'hA5, 1'b1);
        drive_line(0, 1'b1, 20);
        chk("rxA5 valid pulses", nv, 1);
        chk("rxA5 ferr pulses", nf, 0);
        chk("rxA5 data", rxd0, 8'hA5);

        // 0x3C with a bad stop bit; the line stays low afterwards
        nv = 0; nf = 0;
        rx_frame(0, 8'h3C, 1'b0);
        drive_line(0, 1'b0, 3 * DIV);
        chk("rx3C ferr pulses", nf, 1);
        chk("rx3C valid pulses", nv, 0);
        chk("rx3C data held", rxd0, 8'hA5);
        drive_line(0, 1'b1, 2 * DIV);
        chk("rx3C no extra pulses", nv + nf, 1);
        nv = 0; nf = 0;
        rx_frame(0, 8'h96, 1'b1);
        drive_line(0, 1'b1, 20);
        chk("rx96 valid pulses", nv, 1);
        chk("rx96 ferr pulses", nf, 0);
        chk("rx96 data", rxd0, 8'h96);

        // A 50-cycle low glitch is a false start
        nv = 0; nf = 0;
        drive_line(0, 1'b0, 50);
        drive_line(0, 1'b1, 3 * DIV);
        chk("glitch valid pulses", nv, 0);
        chk("glitch ferr pulses", nf, 0);
        chk("glitch data held", rxd0, 8'h96);

        // Echo instance: receive 0x41 and expect it retransmitted
        nv = 0; nf = 0;
        rx_frame(1, 8'h41, 1'b1);
        drive_line(1, 1'b1, 20);
        chk("echo rx valid pulses", nv, 1);
        chk("echo rx data", rxd1, 8'h41);
        for (int i = 0; i < 3000 && !(v1_cyc >= 0 && rise_cyc > v1_cyc); i++) tick;
        chk("echo tx_ready returned", (v1_cyc >= 0 && rise_cyc > v1_cyc), 1);
        chk("echo tx_ready at load", rdy_at_v, 0);
        chk("echo start delay", f_cyc - v1_cyc, 1);
        chk("echo ready delay", rise_cyc - v1_cyc, 10 * DIV);
        chk("echo frames decoded", mon_done, 1);
        chk("echo byte", mon_byte, 8'h41);
        chk("echo stop bit", mon_stop, 1);

        // Second echo frame, aborted by reset while its start bit is on STX
        rx_frame(1, 8'h5A, 1'b1);
        for (int i = 0; i < 500 && stx1 !== 1'b0; i++) tick;
        chk("echo2 started", stx1, 0);
        rst1 = 1'b1; txv1 = 1'b1; txd1 = 8'h00;
        tick;
        chk("rst mid-frame STX", stx1, 1);
        lows = 0;
        repeat (5) begin
            tick;
            if (stx1 !== 1'b1) lows++;
        end
        rst1 = 1'b0; txv1 = 1'b0;
        tick;
        chk("post-rst tx_ready", rdy1, 1);
        chk("post-rst rx_data", rxd1, 8'h00);
        chk("post-rst rx_valid", rxv1, 0);
        repeat (2 * DIV) begin
            tick;
            if (stx1 !== 1'b1) lows++;
        end
        chk("post-rst STX low cycles", lows, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
